// File: rtl/multi_warp_scalar_reg_file_if.sv
// Shared types and the scheduler/writeback bus for the multi-warp scalar register file.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package multi_warp_scalar_reg_file_pkg;

  parameter int unsigned IMEM_ADDR_WIDTH = 16;

  typedef logic [IMEM_ADDR_WIDTH-1:0] instruction_memory_address_t;

  // Writeback source select; encodings 5..7 are invalid
  typedef enum logic [2:0] {
    ALU_OUT          = 3'd0,
    LSU_OUT          = 3'd1,
    IMMEDIATE        = 3'd2,
    PC_PLUS_1        = 3'd3,
    VECTOR_TO_SCALAR = 3'd4
  } reg_input_mux_t;

endpackage

interface multi_warp_scalar_reg_file_if
  import multi_warp_scalar_reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned NUM_WARPS  = 4,
  parameter int unsigned NUM_REGS   = 32
);

  localparam int unsigned WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int unsigned RW = $clog2(NUM_REGS);

  // Issue / read request
  logic                  rd_valid;
  logic [WW-1:0]         rd_warp;
  logic [RW-1:0]         rs1_addr;
  logic [RW-1:0]         rs2_addr;
  logic                  rd_reserve;
  logic [RW-1:0]         rd_addr;
  logic                  rd_ready;

  // Read response
  logic                  rs_valid;
  logic [DATA_WIDTH-1:0] rs1;
  logic [DATA_WIDTH-1:0] rs2;

  // Writeback
  logic                        wb_valid;
  logic [WW-1:0]               wb_warp;
  logic [RW-1:0]               wb_addr;
  reg_input_mux_t              wb_mux;
  logic [DATA_WIDTH-1:0]       alu_out;
  logic [DATA_WIDTH-1:0]       lsu_out;
  logic [DATA_WIDTH-1:0]       wb_immediate;
  logic [DATA_WIDTH-1:0]       vector_to_scalar_data;
  instruction_memory_address_t wb_pc;

  modport master (
    output rd_valid, rd_warp, rs1_addr, rs2_addr, rd_reserve, rd_addr,
    input  rd_ready,
    input  rs_valid, rs1, rs2,
    output wb_valid, wb_warp, wb_addr, wb_mux, alu_out, lsu_out, wb_immediate,
    output vector_to_scalar_data, wb_pc
  );

  modport slave (
    input  rd_valid, rd_warp, rs1_addr, rs2_addr, rd_reserve, rd_addr,
    output rd_ready,
    output rs_valid, rs1, rs2,
    input  wb_valid, wb_warp, wb_addr, wb_mux, alu_out, lsu_out, wb_immediate,
    input  vector_to_scalar_data, wb_pc
  );

endinterface

// File: rtl/multi_warp_scalar_reg_file.sv
// Scalar register file holding NUM_WARPS contexts of NUM_REGS registers each.
// Registered dual read port with writeback bypass, per-register pending bits that
// stall issue on RAW/WAW hazards, and per-warp execution mask export (top register).

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module multi_warp_scalar_reg_file
  import multi_warp_scalar_reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned NUM_WARPS  = 4,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  multi_warp_scalar_reg_file_if.slave                            bus,
  input  logic                                                   warp_clear,
  input  logic [((NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1)-1:0]   warp_clear_id,
  output logic [NUM_WARPS*DATA_WIDTH-1:0]                        exec_mask
);

  localparam int unsigned RW = $clog2(NUM_REGS);

  typedef logic [DATA_WIDTH-1:0] data_t;

  data_t               regs_q    [NUM_WARPS][NUM_REGS];
  logic [NUM_REGS-1:0] pending_q [NUM_WARPS];
  logic [NUM_REGS-1:0] pending_d [NUM_WARPS];

  logic  rs_valid_q;
  data_t rs1_q, rs2_q;
  data_t rs1_d, rs2_d;

  data_t wb_data;
  logic  wb_mux_ok;
  logic  wb_active;
  logic  wb_write;
  logic  wb_clear_hit;
  logic  rd_clear_hit;

  logic [NUM_REGS-1:0] rd_pend;
  logic                hazard;
  logic                rd_ready;
  logic                accept;

  // Context init image: r1 and the mask register all ones, everything else zero
  function automatic data_t init_value(logic [RW-1:0] a);
    if (a == RW'(1) || a == RW'(NUM_REGS - 1)) begin
      return {DATA_WIDTH{1'b1}};
    end
    return {DATA_WIDTH{1'b0}};
  endfunction

  // Writeback source select; an unknown select leaves wb_mux_ok low
  always_comb begin
    wb_data   = '0;
    wb_mux_ok = 1'b1;
    unique case (bus.wb_mux)
      ALU_OUT:          wb_data = bus.alu_out;
      LSU_OUT:          wb_data = bus.lsu_out;
      IMMEDIATE:        wb_data = bus.wb_immediate;
      PC_PLUS_1:        wb_data = data_t'(bus.wb_pc) + data_t'(1);
      VECTOR_TO_SCALAR: wb_data = bus.vector_to_scalar_data;
      default:          wb_mux_ok = 1'b0;
    endcase
  end

  // r0 writes never land and never clear anything (r0 is never pending)
  assign wb_active    = bus.wb_valid && (bus.wb_addr != '0);
  assign wb_write     = wb_active && wb_mux_ok;
  assign wb_clear_hit = warp_clear && (warp_clear_id == bus.wb_warp);
  assign rd_clear_hit = warp_clear && (warp_clear_id == bus.rd_warp);

  // Pending view of the requesting warp, with same-cycle writeback and clear already applied
  always_comb begin
    rd_pend = pending_q[bus.rd_warp];
    if (wb_active && (bus.wb_warp == bus.rd_warp)) begin
      rd_pend[bus.wb_addr] = 1'b0;
    end
    if (rd_clear_hit) begin
      rd_pend = '0;
    end
    rd_pend[0] = 1'b0;
  end

  assign hazard   = rd_pend[bus.rs1_addr] || rd_pend[bus.rs2_addr] ||
                    (bus.rd_reserve && rd_pend[bus.rd_addr]);
  assign rd_ready = !(bus.rd_valid && hazard);
  assign accept   = bus.rd_valid && rd_ready;

  // Read operands: clear beats bypass, bypass beats stored value, r0 always zero
  always_comb begin
    rs1_d = regs_q[bus.rd_warp][bus.rs1_addr];
    rs2_d = regs_q[bus.rd_warp][bus.rs2_addr];
    if (wb_write && (bus.wb_warp == bus.rd_warp)) begin
      if (bus.wb_addr == bus.rs1_addr) rs1_d = wb_data;
      if (bus.wb_addr == bus.rs2_addr) rs2_d = wb_data;
    end
    if (rd_clear_hit) begin
      rs1_d = init_value(bus.rs1_addr);
      rs2_d = init_value(bus.rs2_addr);
    end
    if (bus.rs1_addr == '0) rs1_d = '0;
    if (bus.rs2_addr == '0) rs2_d = '0;
  end

  // Registered read port; data holds when no request is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      rs_valid_q <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
    end else begin
      rs_valid_q <= accept;
      if (accept) begin
        rs1_q <= rs1_d;
        rs2_q <= rs2_d;
      end
    end
  end

  // Scoreboard next state: writeback clears, reserve sets after it, clear overrides both
  always_comb begin
    pending_d = pending_q;
    if (wb_active) begin
      pending_d[bus.wb_warp][bus.wb_addr] = 1'b0;
    end
    if (accept && bus.rd_reserve && (bus.rd_addr != '0)) begin
      pending_d[bus.rd_warp][bus.rd_addr] = 1'b1;
    end
    if (warp_clear) begin
      pending_d[warp_clear_id] = '0;
    end
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        pending_q[w] <= '0;
      end
    end else begin
      pending_q <= pending_d;
    end
  end

  // Register storage: writeback to a warp being cleared is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          regs_q[w][r] <= init_value(RW'(r));
        end
      end
    end else begin
      if (wb_write && !wb_clear_hit) begin
        regs_q[bus.wb_warp][bus.wb_addr] <= wb_data;
      end
      if (warp_clear) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          regs_q[warp_clear_id][r] <= init_value(RW'(r));
        end
      end
    end
  end

`ifndef SYNTHESIS
  // Flag writebacks carrying an undefined source select
  always_ff @(posedge clk) begin
    if (!reset && bus.wb_valid && !wb_mux_ok) begin
      $error("multi_warp_scalar_reg_file: invalid wb_mux %0d", bus.wb_mux);
    end
  end
`endif

  // Export the top register of every warp as its execution mask
  always_comb begin
    exec_mask = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      exec_mask[w*DATA_WIDTH +: DATA_WIDTH] = regs_q[w][NUM_REGS-1];
    end
  end

  assign bus.rd_ready = rd_ready;
  assign bus.rs_valid = rs_valid_q;
  assign bus.rs1      = rs1_q;
  assign bus.rs2      = rs2_q;

endmodule
